vga_timing: RTL
===============

Name: vga_timing

Overview:
- Upstream raster-timing stage that feeds the pixel-colour/sprite stage ahead of the VGA PMOD output.
- Generates the pixel position, sync pulses, a display-active flag, line/frame strobes and a free-running frame counter.
- The colour stage consumes these signals directly and uses frame_count for animation selection.
- Timing is parameterised, and a pixel enable lets the block run from a clock faster than the pixel rate.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync (0 = active-low)
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel-rate enable; position advances only on cycles where it is 1
- pixel_x  out  XW  current column, 0..H_TOTAL-1
- pixel_y  out  YW  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- active  out  1  1 when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
- line_start  out  1  one-clk strobe on entry to pixel_x = 0
- frame_start  out  1  one-clk strobe on entry to (0,0)
- frame_count  out  8  frame counter, incremented on each frame wrap

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (rst).
- All outputs are registered.
- hsync, vsync and active are computed from the next position, so they are aligned with pixel_x/pixel_y on the same cycle (zero skew).
- Reset (rst=1 at a clk edge), which overrides pix_en:
  - pixel_x=0, pixel_y=0, frame_count=0
  - active=1
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - line_start=0, frame_start=0
- Advance on a clk edge with rst=0 and pix_en=1:
  - if pixel_x == H_TOTAL-1: pixel_x becomes 0.
    - Then if pixel_y == V_TOTAL-1: pixel_y becomes 0 and frame_count increments (mod 256, 255 wraps to 0); otherwise pixel_y increments.
  - otherwise pixel_x increments.
- pix_en=0: pixel_x, pixel_y, hsync, vsync, active and frame_count hold; line_start and frame_start are 0.
- hsync is asserted iff H_ACTIVE+H_FRONT <= pixel_x < H_ACTIVE+H_FRONT+H_SYNC (656..751 with defaults).
- vsync is asserted iff V_ACTIVE+V_FRONT <= pixel_y < V_ACTIVE+V_FRONT+V_SYNC (490..491 with defaults).
  - vsync changes together with pixel_y, i.e. on the x-wrap cycle.
- Strobes:
  - line_start=1 for exactly the one clk cycle following an advance that produced pixel_x=0.
  - frame_start=1 on the same cycle when that advance also produced pixel_y=0.
  - Neither strobe fires after reset.
- Period with pix_en held at 1: each line is H_TOTAL clk cycles (800 with defaults) and each frame is H_TOTAL*V_TOTAL clk cycles (420000 with defaults).
- Invariants:
  - pixel_x never reaches H_TOTAL and pixel_y never reaches V_TOTAL.
  - Out-of-range values cannot arise, since only the reset state and wrap paths load the counters.
- Arithmetic:
  - Compare constants are sized to XW/YW.
  - frame_count wraps naturally at 8 bits.
- Reset mid-frame:
  - The next cycle shows the reset state; no strobe fires.
  - The first advance after reset moves to (1,0).

Test Plan:
- Reset then pix_en=1 for 800 clk cycles:
  - pixel_x runs 0..799 and then returns to 0 with pixel_y=1.
  - line_start pulses exactly once, on the cycle showing x=0,y=1.
  - hsync is low for exactly 96 cycles, starting at x=656.
- Run 420000 clk cycles with pix_en=1:
  - frame_start is seen once, coincident with (0,0).
  - frame_count=1.
  - vsync is low only while y is 490 or 491 (1600 cycles).
  - active is 1 for exactly 307200 cycles.
- pix_en toggling 1,0,1,0:
  - position advances every other clk; strobes never fire on pix_en=0 cycles.
  - A line takes 1600 clk cycles.
- Force 256 frames (small parameters, e.g. H_TOTAL=4, V_TOTAL=3): frame_count goes 255 -> 0 on the 256th frame wrap, and frame_start still pulses.
- HSYNC_POL=1, VSYNC_POL=1: sync outputs idle low after reset and go high during the same x/y windows as above.
- Assert rst at x=700, y=491 (both syncs asserted) for one clk:
  - next cycle shows (0,0) with syncs inactive, active=1, frame_count=0 and no strobes.
  - The following pix_en cycle shows (1,0).

Source files
------------

// File: rtl/vga_timing.sv
// Raster timing generator: pixel position, sync pulses, display-active flag,
// line/frame strobes and a free-running 8-bit frame counter, all registered.
module vga_timing #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned XW       = $clog2(H_TOTAL),
    localparam int unsigned YW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    // Window bounds carry one extra bit so an end bound equal to 2**XW still fits.
    localparam logic [XW:0] X_ACT = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0] HS_BEG = (XW+1)'(H_ACTIVE + H_FRONT);
    localparam logic [XW:0] HS_END = (XW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [YW:0] Y_ACT = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0] VS_BEG = (YW+1)'(V_ACTIVE + V_FRONT);
    localparam logic [YW:0] VS_END = (YW+1)'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;
    logic [7:0]    fc_nxt;
    logic          hs_nxt;
    logic          vs_nxt;
    logic          act_nxt;

    always_comb begin
        x_nxt  = pixel_x + 1'b1;
        y_nxt  = pixel_y;
        fc_nxt = frame_count;
        if (pixel_x == X_LAST) begin
            x_nxt = '0;
            if (pixel_y == Y_LAST) begin
                y_nxt  = '0;
                fc_nxt = frame_count + 8'd1;
            end else begin
                y_nxt = pixel_y + 1'b1;
            end
        end
    end

    // Decode from the next position so syncs and active line up with the counters.
    always_comb begin
        hs_nxt  = ({1'b0, x_nxt} >= HS_BEG) && ({1'b0, x_nxt} < HS_END);
        vs_nxt  = ({1'b0, y_nxt} >= VS_BEG) && ({1'b0, y_nxt} < VS_END);
        act_nxt = ({1'b0, x_nxt} < X_ACT) && ({1'b0, y_nxt} < Y_ACT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_count <= 8'd0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            active      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            pixel_x     <= x_nxt;
            pixel_y     <= y_nxt;
            frame_count <= fc_nxt;
            hsync       <= hs_nxt ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_nxt ? VSYNC_POL : ~VSYNC_POL;
            active      <= act_nxt;
            line_start  <= (x_nxt == '0);
            frame_start <= (x_nxt == '0) && (y_nxt == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
